// File: rtl/replay_mem_ctrl_pkg.sv
// Shared types and default sizing for the replay buffer controller.
package replay_mem_ctrl_pkg;

    localparam int unsigned DEF_WIDTH      = 12;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_MEM_DEPTH  = 64;

    typedef enum logic [0:0] {
        RSP_IDLE = 1'b0,
        RSP_BUSY = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/replay_mem_ctrl_if.sv
// Bus bundle between the replay controller, its requester and its memory.
interface replay_mem_ctrl_if
    import replay_mem_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  flush;
    logic                  wrValid;
    logic                  wrReady;
    logic [WIDTH-1:0]      wrData;
    logic                  rdReqValid;
    logic                  rdReqReady;
    logic [ADDR_WIDTH-1:0] rdReqIdx;
    logic                  rdRspValid;
    logic                  rdRspReady;
    logic [WIDTH-1:0]      rdRspData;
    logic                  rdRspErr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  memWrEna;
    logic [ADDR_WIDTH-1:0] memWrAddr;
    logic [WIDTH-1:0]      memWrData;
    logic                  memRdEna;
    logic [ADDR_WIDTH-1:0] memRdAddr;
    logic [WIDTH-1:0]      memRdData;

    modport slave (
        input  flush, wrValid, wrData, rdReqValid, rdReqIdx, rdRspReady, memRdData,
        output wrReady, rdReqReady, rdRspValid, rdRspData, rdRspErr, count, full,
               memWrEna, memWrAddr, memWrData, memRdEna, memRdAddr
    );

    modport master (
        output flush, wrValid, wrData, rdReqValid, rdReqIdx, rdRspReady, memRdData,
        input  wrReady, rdReqReady, rdRspValid, rdRspData, rdRspErr, count, full,
               memWrEna, memWrAddr, memWrData, memRdEna, memRdAddr
    );

endinterface

// File: rtl/replay_mem_ctrl_wrap_ptr.sv
// Circular pointer: synchronous clear, increment with wrap from last slot to 0.
module wrap_ptr #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Next pointer value; clear wins over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = {ADDR_WIDTH{1'b0}};
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST_PTR) ? {ADDR_WIDTH{1'b0}} : ptr_q + ADDR_WIDTH'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/replay_mem_ctrl.sv
// Circular replay buffer controller: pushes overwrite the oldest entry when full,
// reads address entries by age (0 = oldest) with a one-cycle response.
module replay_mem_ctrl
    import replay_mem_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic             clock,
    input  logic             resetN,
    replay_mem_ctrl_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] head_s;
    logic [ADDR_WIDTH-1:0] tail_s;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  full_q;
    logic                  full_d;
    rsp_state_e            state_q;
    rsp_state_e            state_d;
    logic                  err_q;
    logic                  err_d;

    logic                  push_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  collision_s;
    logic                  req_ready_s;
    logic                  accept_s;

    assign push_s      = bus.wrValid & ~bus.flush;
    assign in_range_s  = ({1'b0, bus.rdReqIdx} < count_q);
    assign rd_addr_s   = tail_s + bus.rdReqIdx;
    // Only possible when full and idx 0: the slot being read is overwritten this cycle.
    assign collision_s = push_s & in_range_s & (rd_addr_s == head_s);
    assign req_ready_s = ((state_q == RSP_IDLE) | bus.rdRspReady) & ~bus.flush & ~collision_s;
    assign accept_s    = bus.rdReqValid & req_ready_s;

    wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_head (
        .clock  (clock),
        .resetN (resetN),
        .clr_i  (bus.flush),
        .inc_i  (push_s),
        .ptr_o  (head_s)
    );

    wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_tail (
        .clock  (clock),
        .resetN (resetN),
        .clr_i  (bus.flush),
        .inc_i  (push_s & full_q),
        .ptr_o  (tail_s)
    );

    // Occupancy count and full flag for the next cycle.
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = {(ADDR_WIDTH+1){1'b0}};
        end else if (push_s && !full_q) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else begin
            count_d = count_q;
        end
        full_d = (count_d == DEPTH_CNT);
    end

    // Response FSM next state and error flag.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (bus.flush) begin
            state_d = RSP_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                RSP_IDLE: begin
                    if (accept_s) begin
                        state_d = RSP_BUSY;
                        err_d   = ~in_range_s;
                    end else begin
                        state_d = RSP_IDLE;
                        err_d   = 1'b0;
                    end
                end
                RSP_BUSY: begin
                    if (accept_s) begin
                        state_d = RSP_BUSY;
                        err_d   = ~in_range_s;
                    end else if (bus.rdRspReady) begin
                        state_d = RSP_IDLE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RSP_BUSY;
                        err_d   = err_q;
                    end
                end
                default: begin
                    state_d = RSP_IDLE;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q <= {(ADDR_WIDTH+1){1'b0}};
            full_q  <= 1'b0;
            state_q <= RSP_IDLE;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.wrReady    = ~bus.flush;
    assign bus.memWrEna   = push_s;
    assign bus.memWrAddr  = head_s;
    assign bus.memWrData  = bus.wrData;
    assign bus.rdReqReady = req_ready_s;
    assign bus.memRdEna   = accept_s & in_range_s;
    assign bus.memRdAddr  = rd_addr_s;
    assign bus.rdRspValid = (state_q == RSP_BUSY);
    assign bus.rdRspErr   = err_q;
    // Memory holds its read data while memRdEna is low, so a stalled response stays stable.
    assign bus.rdRspData  = ((state_q == RSP_BUSY) && !err_q) ? bus.memRdData : {WIDTH{1'b0}};
    assign bus.count      = count_q;
    assign bus.full       = full_q;

endmodule

// File: doc/replay_mem_ctrl.md
REPLAY_MEM_CTRL -- requirements
Module: replay_mem_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 12, entry width; MEM_DEPTH, default 64, entries (SHALL equal 2**ADDR_WIDTH); ADDR_WIDTH, default 6, address width.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 resetN  in  1  reset, asynchronous assert, active-low.
REQ-004 flush  in  1  pulse that empties the buffer.
REQ-005 wrValid  in  1 / wrReady  out  1 / wrData  in  WIDTH  push handshake for the newest entry.
REQ-006 rdReqValid  in  1 / rdReqReady  out  1 / rdReqIdx  in  ADDR_WIDTH  read request; logical index, 0 = oldest entry.
REQ-007 rdRspValid  out  1 / rdRspReady  in  1 / rdRspData  out  WIDTH / rdRspErr  out  1  read response handshake.
REQ-008 count  out  ADDR_WIDTH+1  valid entries; full  out  1  count == MEM_DEPTH.
REQ-009 memWrEna  out  1 / memWrAddr  out  ADDR_WIDTH / memWrData  out  WIDTH  memory write port.
REQ-010 memRdEna  out  1 / memRdAddr  out  ADDR_WIDTH / memRdData  in  WIDTH  memory read port; 1-cycle registered read; output held while memRdEna=0.

Function
REQ-011 Buffer SHALL be circular: head = next write slot, tail = oldest slot; both wrap MEM_DEPTH-1 -> 0.
REQ-012 wrReady SHALL be 1 except in a flush cycle; a push (wrValid&wrReady) SHALL drive memWrEna=1, memWrAddr=head, memWrData=wrData combinationally and advance head by 1.
REQ-013 Push when not full: count += 1; push when full: count unchanged, tail += 1 (oldest entry overwritten).
REQ-014 Physical read address SHALL be (tail + rdReqIdx) mod MEM_DEPTH, computed with current-cycle tail.
REQ-015 rdReqReady = (!rdRspValid | rdRspReady) & !flush & !collision; collision = push this cycle & in-range request & physical read address == head.
REQ-016 Accepted in-range request (rdReqIdx < count) SHALL drive memRdEna=1, memRdAddr=physical address that cycle; rdRspValid=1, rdRspErr=0 the next cycle; rdRspData = memRdData.
REQ-017 Accepted out-of-range request (rdReqIdx >= count) SHALL NOT assert memRdEna; next cycle rdRspValid=1, rdRspErr=1, rdRspData=0.
REQ-018 Read latency SHALL be exactly 1 cycle accept-to-response; back-to-back accepts SHALL sustain 1 response/cycle while rdRspReady=1.
REQ-019 While rdRspValid=1 and rdRspReady=0, memRdEna SHALL be 0 and rdRspData/rdRspErr SHALL hold stable.
REQ-020 rdRspValid SHALL clear the cycle after a response handshake with no new accept.
REQ-021 Response FSM: IDLE (no rsp) -> RSP on accept; RSP -> RSP on handshake+accept or stall; RSP -> IDLE on handshake without accept.
REQ-022 flush SHALL take priority over push and read: next cycle head=tail=0, count=0, rdRspValid=0 (pending response dropped); memWrEna and memRdEna SHALL be 0 in the flush cycle.
REQ-023 full SHALL be a registered/decoded flag consistent with count in the same cycle.

Reset
REQ-024 On resetN low, head, tail, count SHALL be 0; full, rdRspValid, rdRspErr SHALL be 0; FSM SHALL be IDLE; rdRspData SHALL be 0 when rdRspValid=0.
REQ-025 Reset mid-transaction SHALL discard any pending response; first response after release requires a fresh accept.

Structure
REQ-026 Shared package SHALL hold the response FSM state enum and the default WIDTH/MEM_DEPTH/ADDR_WIDTH constants.
REQ-027 Pointer wrap/increment SHALL be one sub-module, wrap_ptr, instantiated for head and tail; memory instance stays outside this block.

Verification
REQ-028 Push 0x001..0x005, read idx 0..4 with rdRspReady=1 -> data 0x001..0x005, err=0, each 1 cycle after accept, count=5.
REQ-029 Push 70 entries (0x000..0x045) -> full=1, count=64; idx 0 returns 0x006, idx 63 returns 0x045.
REQ-030 count=3, request idx 3 -> rdRspErr=1, rdRspData=0, memRdEna never asserted.
REQ-031 Response valid, rdRspReady=0 for 4 cycles -> rdRspData stable, rdReqReady=0, memRdEna=0; release -> next request accepted same cycle.
REQ-032 Full buffer, push plus read of idx 0 in same cycle -> rdReqReady=0 that cycle; request accepted next cycle and returns the new oldest entry.
REQ-033 flush with response pending, and resetN low mid-read -> rdRspValid=0, count=0 next cycle; subsequent idx 0 read -> err=1.
